// File: rtl/dm_hash_ctrl_pkg.sv
// rtl/dm_hash_ctrl_pkg.sv - shared types and widths for the DM-PRESENT hash sequencer
`timescale 1ns/1ps

package dm_hash_ctrl_pkg;

    localparam int DAT_W = 64;   // chaining value / digest width
    localparam int KEY_W = 80;   // message block width (core key)

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        OUT     = 3'd4,
        ERR     = 3'd5
    } state_t;

endpackage

// File: rtl/dm_hash_ctrl.sv
// rtl/dm_hash_ctrl.sv - Davies-Meyer PRESENT multi-block hash sequencer
//
// Purpose: takes pre-padded 80-bit message blocks over valid/ready, runs each
// through the external DM-PRESENT compression core (block = key, running
// chaining value = data) and returns the final chaining value as the digest.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   abort                 synchronous abandon of the current message
//   msg_valid/ready/data/last   block input handshake
//   dig_valid/ready/data  digest output handshake
//   core_reset/load/idat/key    drive to the compression core
//   core_odat/done        result and done flag from the core
//   busy, err, blk_cnt    status: not idle, sticky timeout, blocks compressed
`timescale 1ns/1ps

module dm_hash_ctrl
    import dm_hash_ctrl_pkg::*;
#(
    parameter logic [DAT_W-1:0] IV      = '0,
    parameter int               TIMEOUT = 64,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  logic [KEY_W-1:0] msg_data,
    input  logic             msg_last,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [DAT_W-1:0] dig_data,
    output logic             core_reset,
    output logic             core_load,
    output logic [DAT_W-1:0] core_idat,
    output logic [KEY_W-1:0] core_key,
    input  logic [DAT_W-1:0] core_odat,
    input  logic             core_done,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam int              TC_W    = $clog2(TIMEOUT + 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;

    logic [DAT_W-1:0]   r_h;
    logic               r_last;
    logic               r_first;
    logic [TC_W-1:0]    r_tcnt;
    logic               r_core_reset;
    logic               r_core_load;
    logic [DAT_W-1:0]   r_core_idat;
    logic [KEY_W-1:0]   r_core_key;
    logic               r_dig_valid;
    logic [DAT_W-1:0]   r_dig_data;
    logic               r_err;
    logic [CNT_W-1:0]   r_blk_cnt;

    logic               w_msg_ready;
    logic               w_accept;
    logic               w_in_wait;
    logic               w_capture;
    logic               w_timeout;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_next = LOAD;
                LOAD:    w_next = WAIT_LO;
                // core_done is still high from the previous operation (and can
                // pulse stale right after load), so see it low before trusting it
                WAIT_LO: begin
                    if (w_timeout)       w_next = ERR;
                    else if (!core_done) w_next = WAIT_HI;
                end
                WAIT_HI: begin
                    if (w_capture)       w_next = r_last ? OUT : IDLE;
                    else if (w_timeout)  w_next = ERR;
                end
                OUT:     if (dig_ready) w_next = IDLE;
                ERR:     w_next = ERR;
                default: w_next = IDLE;
            endcase
        end
    end

    // Output / strobe decode
    always_comb begin
        // Blocks are refused while the core itself is held in reset
        w_msg_ready = (r_state == IDLE) && !abort && !r_core_reset;
        w_accept    = w_msg_ready && msg_valid;
        w_in_wait   = (r_state == WAIT_LO) || (r_state == WAIT_HI);
        w_capture   = (r_state == WAIT_HI) && core_done;
        // A completion in the last allowed cycle still wins over the fault
        w_timeout   = w_in_wait && (r_tcnt == TC_LAST) && !w_capture;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h          <= IV;
            r_last       <= 1'b0;
            r_first      <= 1'b1;
            r_tcnt       <= '0;
            r_core_reset <= 1'b1;
            r_core_load  <= 1'b0;
            r_core_idat  <= '0;
            r_core_key   <= '0;
            r_dig_valid  <= 1'b0;
            r_dig_data   <= '0;
            r_err        <= 1'b0;
            r_blk_cnt    <= '0;
        end else if (abort) begin
            r_first      <= 1'b1;
            r_h          <= IV;
            r_dig_valid  <= 1'b0;
            r_core_load  <= 1'b0;
            r_core_reset <= 1'b1;
            r_err        <= 1'b0;
            r_blk_cnt    <= '0;
        end else begin
            r_core_reset <= 1'b0;
            // Registered so the strobe is high exactly during LOAD
            r_core_load  <= w_accept;

            if (w_accept) begin
                r_core_key  <= msg_data;
                r_core_idat <= r_first ? IV : r_h;
                r_last      <= msg_last;
                r_first     <= 1'b0;
                if (r_first) begin
                    r_blk_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (!(&r_blk_cnt)) begin
                    r_blk_cnt <= r_blk_cnt + 1'b1;
                end
            end

            if (r_state == LOAD) begin
                r_tcnt <= '0;
            end else if (w_in_wait) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if (w_capture) begin
                r_h <= core_odat;
                if (r_last) begin
                    r_dig_data  <= core_odat;
                    r_dig_valid <= 1'b1;
                end
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end

            if ((r_state == OUT) && dig_ready) begin
                r_dig_valid <= 1'b0;
                r_first     <= 1'b1;
            end
        end
    end

    assign msg_ready  = w_msg_ready;
    assign busy       = (r_state != IDLE);
    assign err        = r_err;
    assign blk_cnt    = r_blk_cnt;
    assign dig_valid  = r_dig_valid;
    assign dig_data   = r_dig_data;
    assign core_reset = r_core_reset;
    assign core_load  = r_core_load;
    assign core_idat  = r_core_idat;
    assign core_key   = r_core_key;

endmodule

// File: tb/tb_dm_hash_ctrl.sv
// tb/tb_dm_hash_ctrl.sv - directed self-checking bench for dm_hash_ctrl
`timescale 1ns/1ps

module tb_dm_hash_ctrl;

    localparam int LAT = 34;

    logic             clk = 1'b0;
    logic             reset;
    logic             abort;
    logic [79:0]      msg_data;
    logic             msg_last;
    logic [1:0]       msg_valid;
    logic [1:0]       msg_ready;
    logic [1:0]       dig_valid;
    logic [1:0]       dig_ready;
    logic [1:0][63:0] dig_data;
    logic [1:0]       core_reset;
    logic [1:0]       core_load;
    logic [1:0]       busy;
    logic [1:0]       err;
    logic [1:0][15:0] blk_cnt;
    logic [1:0]       stuck;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC; 4'h1: sbox = 4'h5; 4'h2: sbox = 4'h6; 4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9; 4'h5: sbox = 4'h0; 4'h6: sbox = 4'hA; 4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3; 4'h9: sbox = 4'hE; 4'hA: sbox = 4'hF; 4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4; 4'hD: sbox = 4'h7; 4'hE: sbox = 4'h1; default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s;
        logic [63:0] p;
        logic [79:0] k;
        logic [4:0]  rc;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[n*4 +: 4] = sbox(s[n*4 +: 4]);
            p = '0;
            for (int b = 0; b < 63; b++) p[(b*16) % 63] = s[b];
            p[63] = s[63];
            s = p;
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox(k[79:76]);
            rc = 5'(r);
            k[19:15] = k[19:15] ^ rc;
        end
        present80 = s ^ k[79:16];
    endfunction

    function automatic logic [63:0] dm(input logic [63:0] h, input logic [79:0] m);
        dm = present80(h, m) ^ h;
    endfunction

    // Instance 0 uses IV=0, instance 1 uses IV=all-ones; each has its own core model
    for (genvar g = 0; g < 2; g++) begin : gi
        logic        c_done = 1'b0;
        logic        c_act  = 1'b0;
        logic [63:0] c_odat = '0;
        logic [63:0] c_res  = '0;
        logic [63:0] c_idat;
        logic [79:0] c_key;
        int          c_cnt  = 0;

        dm_hash_ctrl #(
            .IV      (g == 0 ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF),
            .TIMEOUT (64),
            .CNT_W   (16)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .abort      (abort),
            .msg_valid  (msg_valid[g]),
            .msg_ready  (msg_ready[g]),
            .msg_data   (msg_data),
            .msg_last   (msg_last),
            .dig_valid  (dig_valid[g]),
            .dig_ready  (dig_ready[g]),
            .dig_data   (dig_data[g]),
            .core_reset (core_reset[g]),
            .core_load  (core_load[g]),
            .core_idat  (c_idat),
            .core_key   (c_key),
            .core_odat  (c_odat),
            .core_done  (c_done),
            .busy       (busy[g]),
            .err        (err[g]),
            .blk_cnt    (blk_cnt[g])
        );

        // done stays high from the previous op and stays high one cycle after load
        always @(posedge clk) begin
            if (core_reset[g]) begin
                c_done <= 1'b0;
                c_act  <= 1'b0;
                c_cnt  <= 0;
            end else if (core_load[g]) begin
                c_done <= 1'b1;
                c_act  <= 1'b1;
                c_cnt  <= 0;
                c_res  <= dm(c_idat, c_key);
            end else if (c_act) begin
                if (stuck[g]) begin
                    c_done <= 1'b1;
                end else if (c_cnt == LAT) begin
                    c_done <= 1'b1;
                    c_odat <= c_res;
                    c_act  <= 1'b0;
                end else begin
                    c_done <= 1'b0;
                    c_cnt  <= c_cnt + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input int g, input logic [79:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (!msg_ready[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 80'(msg_ready[g]), 80'h1);
        msg_data     = d;
        msg_last     = l;
        msg_valid[g] = 1'b1;
        @(posedge clk);
        #1;
        msg_valid[g] = 1'b0;
    endtask

    task automatic wait_dig(input int g);
        int n;
        n = 0;
        @(negedge clk);
        while (!dig_valid[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("dig_valid_wait", 80'(dig_valid[g]), 80'h1);
    endtask

    task automatic consume(input int g);
        @(negedge clk);
        dig_ready[g] = 1'b1;
        @(posedge clk);
        #1;
        dig_ready[g] = 1'b0;
        chk("consume_valid", 80'(dig_valid[g]), 80'h0);
        chk("consume_busy", 80'(busy[g]), 80'h0);
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    logic [63:0] e3;
    logic [63:0] held;
    int          n;

    initial begin
        reset = 1'b1; abort = 1'b0; msg_data = '0; msg_last = 1'b0;
        msg_valid = '0; dig_ready = '0; stuck = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_reset", 80'(core_reset[0]), 80'h1);
        chk("rst_msg_ready", 80'(msg_ready[0]), 80'h0);
        chk("rst_busy", 80'(busy[0]), 80'h0);
        chk("rst_err", 80'(err[0]), 80'h0);
        chk("rst_dig_valid", 80'(dig_valid[0]), 80'h0);
        chk("rst_blk_cnt", 80'(blk_cnt[0]), 80'h0);
        chk("rst_core_load", 80'(core_load[0]), 80'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_core_reset", 80'(core_reset[0]), 80'h0);
        chk("rel_msg_ready", 80'(msg_ready[0]), 80'h1);

        // 1: IV=0, single zero block
        send(0, 80'h0, 1'b1);
        chk("t1_load", 80'(core_load[0]), 80'h1);
        chk("t1_ready_low", 80'(msg_ready[0]), 80'h0);
        wait_dig(0);
        chk("t1_digest", 80'(dig_data[0]), 80'h5579C1387B228445);
        chk("t1_blk_cnt", 80'(blk_cnt[0]), 80'h1);
        held = dig_data[0];
        repeat (5) @(negedge clk);
        chk("t1_hold_valid", 80'(dig_valid[0]), 80'h1);
        chk("t1_hold_data", 80'(dig_data[0]), 80'(held));
        consume(0);

        // 2: IV=all-ones, single zero block
        send(1, 80'h0, 1'b1);
        wait_dig(1);
        chk("t2_digest", 80'(dig_data[1]), 80'h5EED0038D097BE84);
        consume(1);

        // 3: three-block chain
        e3 = dm(dm(dm(64'h0, 80'h0), {80{1'b1}}), 80'h0);
        send(0, 80'h0, 1'b0);
        repeat (10) @(negedge clk);
        chk("t3_ready_low_b1", 80'(msg_ready[0]), 80'h0);
        send(0, {80{1'b1}}, 1'b0);
        repeat (10) @(negedge clk);
        chk("t3_ready_low_b2", 80'(msg_ready[0]), 80'h0);
        chk("t3_no_dig_mid", 80'(dig_valid[0]), 80'h0);
        send(0, 80'h0, 1'b1);
        wait_dig(0);
        chk("t3_digest", 80'(dig_data[0]), 80'(e3));
        chk("t3_blk_cnt", 80'(blk_cnt[0]), 80'h3);
        consume(0);

        // 4: core done stuck high -> timeout, then abort
        stuck[0] = 1'b1;
        send(0, 80'h0, 1'b1);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (err[0]) break;
        end
        chk("t4_err_cycles", 80'(n), 80'd65);
        chk("t4_err", 80'(err[0]), 80'h1);
        repeat (5) @(negedge clk);
        chk("t4_err_sticky", 80'(err[0]), 80'h1);
        chk("t4_busy", 80'(busy[0]), 80'h1);
        chk("t4_ready_low", 80'(msg_ready[0]), 80'h0);
        chk("t4_dig_low", 80'(dig_valid[0]), 80'h0);
        stuck[0] = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        msg_valid[0] = 1'b1;
        msg_data = 80'h0;
        msg_last = 1'b1;
        #1;
        chk("t4_abort_ready", 80'(msg_ready[0]), 80'h0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        msg_valid[0] = 1'b0;
        chk("t4_abort_err", 80'(err[0]), 80'h0);
        chk("t4_abort_busy", 80'(busy[0]), 80'h0);
        chk("t4_abort_core_rst", 80'(core_reset[0]), 80'h1);
        chk("t4_abort_blk_cnt", 80'(blk_cnt[0]), 80'h0);
        @(posedge clk);
        #1;
        chk("t4_core_rst_1cyc", 80'(core_reset[0]), 80'h0);
        chk("t4_not_accepted", 80'(busy[0]), 80'h0);

        // 5: abort in WAIT_HI of block 2, then fresh single-block message
        send(0, {80{1'b1}}, 1'b0);
        send(0, {80{1'b1}}, 1'b0);
        repeat (10) @(negedge clk);
        chk("t5_busy_mid", 80'(busy[0]), 80'h1);
        pulse_abort();
        chk("t5_abort_blk_cnt", 80'(blk_cnt[0]), 80'h0);
        chk("t5_abort_busy", 80'(busy[0]), 80'h0);
        send(0, 80'h0, 1'b1);
        wait_dig(0);
        chk("t5_digest", 80'(dig_data[0]), 80'h5579C1387B228445);
        chk("t5_blk_cnt", 80'(blk_cnt[0]), 80'h1);
        consume(0);

        // 6: async reset mid-LOAD and mid-OUT
        send(0, {80{1'b1}}, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_load_core_rst", 80'(core_reset[0]), 80'h1);
        chk("t6_load_core_load", 80'(core_load[0]), 80'h0);
        chk("t6_load_busy", 80'(busy[0]), 80'h0);
        chk("t6_load_ready", 80'(msg_ready[0]), 80'h0);
        chk("t6_load_blk_cnt", 80'(blk_cnt[0]), 80'h0);
        chk("t6_load_key", gi[0].c_key, 80'h0);
        @(negedge clk);
        reset = 1'b0;
        send(0, 80'h0, 1'b1);
        wait_dig(0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_out_dig_valid", 80'(dig_valid[0]), 80'h0);
        chk("t6_out_dig_data", 80'(dig_data[0]), 80'h0);
        chk("t6_out_core_rst", 80'(core_reset[0]), 80'h1);
        chk("t6_out_busy", 80'(busy[0]), 80'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
